// File: rtl/load_store_unit.sv
// Memory-access stage: issues one req/ack data-memory transaction at a time and returns
// lane-aligned, extended load data to writeback; flags misaligned, illegal and timed-out accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_err,
  output logic [1:0]  err_code,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic [31:0]   addr_q;
  logic [4:0]    rd_q;

  logic          accept;
  logic          f3_legal;
  logic          misaligned;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          to_hit;

  assign accept = op_valid & op_ready;
  assign to_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt) == 32'(TIMEOUT_CYCLES - 1));

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = op_wdata;
    if (op_store)
      f3_legal = op_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_legal = op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (op_funct3[1:0])
      2'b01:   misaligned = op_addr[0];
      2'b10:   misaligned = |op_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (op_store) begin
      case (op_funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << op_addr[1:0];
          wdata_next = {4{op_wdata[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << {op_addr[1], 1'b0};
          wdata_next = {2{op_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h000000, shifted[7:0]};
      3'b101:  load_data = {16'h0000, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Reset abandons any in-flight access; ack outside ACCESS has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      funct3_q   <= '0;
      lane_q     <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      op_ready   <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      lsu_err    <= 1'b0;
      err_code   <= '0;
      fault_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_ready <= 1'b0;
            funct3_q <= op_funct3;
            lane_q   <= op_addr[1:0];
            addr_q   <= op_addr;
            rd_q     <= op_rd;
            if (!f3_legal || misaligned) begin
              state      <= ERR;
              lsu_err    <= 1'b1;
              err_code   <= !f3_legal ? 2'b10 : 2'b01;
              fault_addr <= op_addr;
            end else begin
              state     <= ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= op_store;
              mem_addr  <= {op_addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state    <= IDLE;
              op_ready <= 1'b1;
            end else begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= load_data;
            end
          end else if (to_hit) begin
            mem_req    <= 1'b0;
            state      <= ERR;
            lsu_err    <= 1'b1;
            err_code   <= 2'b11;
            fault_addr <= addr_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP, ERR: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
